// File: rtl/jk_cmd_seq_if.sv
// Command handshake bundle for jk_cmd_seq: valid/ready plus the op, mask and repeat fields.
// The master drives a command and the slave (the sequencer) answers with ready.
interface jk_cmd_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [WIDTH-1:0] CMD_MASK;
  logic [CNT_W-1:0] CMD_REP;

  modport master (
    output CMD_VALID,
    output CMD_OP,
    output CMD_MASK,
    output CMD_REP,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_OP,
    input  CMD_MASK,
    input  CMD_REP,
    output CMD_READY
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// Command sequencer for a bank of JK cells: turns set/clear/toggle/hold commands into J/K/SN/RN
// drive, tracks the expected cell state in SHADOW and flags disagreement with the Q feedback.
module jk_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  jk_cmd_seq_if.slave      cmd,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] SN,
  output logic [WIDTH-1:0] RN,
  input  logic [WIDTH-1:0] Q_FB,
  output logic             BUSY,
  output logic [WIDTH-1:0] SHADOW,
  output logic             ERR,
  output logic [WIDTH-1:0] ERR_MASK
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_errMask;
  logic             r_rstd;

  logic             w_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_count;
  logic [WIDTH-1:0] w_shadowNext;
  logic [WIDTH-1:0] w_errMask;

  // r_rstd marks the cycle following a reset edge, so the cells get cleared through RN.
  assign w_ready  = (r_state == ST_IDLE) && !r_rstd;
  assign w_accept = w_ready && cmd.CMD_VALID;
  assign w_count  = ((cmd.CMD_OP == OP_TOGGLE) && (cmd.CMD_REP != '0)) ? cmd.CMD_REP : CNT_ONE;

  always_comb begin
    w_shadowNext = r_shadow;
    case (r_op)
      OP_SET:    w_shadowNext = r_shadow | r_mask;
      OP_CLEAR:  w_shadowNext = r_shadow & ~r_mask;
      OP_TOGGLE: w_shadowNext = r_shadow ^ r_mask;
      default:   w_shadowNext = r_shadow;
    endcase
  end

  assign w_errMask = r_errMask | ((r_state == ST_CHECK) ? (Q_FB ^ r_shadow) : '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_HOLD;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_errMask <= '0;
      r_rstd    <= 1'b1;
    end else begin
      r_rstd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd.CMD_OP;
            r_mask  <= cmd.CMD_MASK;
            r_cnt   <= w_count;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_shadow <= w_shadowNext;
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_CHECK: begin
          r_errMask <= w_errMask;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Only masked bits leave idle drive; SN and RN are never pulled low together.
  always_comb begin
    J  = '0;
    K  = '0;
    SN = '1;
    RN = '1;
    if (r_rstd) begin
      RN = '0;
    end else if (r_state == ST_DRIVE) begin
      case (r_op)
        OP_SET:    SN = ~r_mask;
        OP_CLEAR:  RN = ~r_mask;
        OP_TOGGLE: begin
          J = r_mask;
          K = r_mask;
        end
        default: ;
      endcase
    end
  end

  assign cmd.CMD_READY = w_ready;
  assign BUSY          = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
  assign SHADOW        = r_shadow;
  assign ERR_MASK      = w_errMask;
  assign ERR           = |w_errMask;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq: an ideal JK cell bank closes the Q loop, a vector table
// covers single commands, and hand-written sequences cover reset, faults and back-to-back handshakes.
module tb_jk_cmd_seq;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef struct {
    logic [1:0] op;
    logic [3:0] mask;
    logic [7:0] rep;
    int         cycles;
    logic [3:0] expJ;
    logic [3:0] expK;
    logic [3:0] expSN;
    logic [3:0] expRN;
    logic [3:0] expShadow;
    logic [3:0] expErrMask;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] j, k, sn, rn;
  logic [3:0] qFb;
  logic       busy;
  logic [3:0] shadow;
  logic       err;
  logic [3:0] errMask;
  logic [3:0] cellQ;
  logic [3:0] stuckMask;

  int nChecks = 0;
  int nMis    = 0;

  vec_t vecs[9];

  jk_cmd_seq_if #(.WIDTH(4), .CNT_W(8)) cmdIf ();

  jk_cmd_seq #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .cmd      (cmdIf),
    .J        (j),
    .K        (k),
    .SN       (sn),
    .RN       (rn),
    .Q_FB     (qFb),
    .BUSY     (busy),
    .SHADOW   (shadow),
    .ERR      (err),
    .ERR_MASK (errMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal JK bank: synchronous, RN wins over SN, then J/K.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!rn[b])      cellQ[b] <= 1'b0;
      else if (!sn[b]) cellQ[b] <= 1'b1;
      else begin
        case ({j[b], k[b]})
          2'b01:   cellQ[b] <= 1'b0;
          2'b10:   cellQ[b] <= 1'b1;
          2'b11:   cellQ[b] <= ~cellQ[b];
          default: cellQ[b] <= cellQ[b];
        endcase
      end
    end
  end

  assign qFb = cellQ & ~stuckMask;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered and left on a negedge; holds reset for n edges and checks the reset drive.
  task automatic resetDut(input int n);
    rst = 1'b1;
    cmdIf.CMD_VALID = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checkOutput("reset RN", rn, 4'h0);
      checkOutput("reset SN/J/K", {sn, j, k}, {4'hF, 4'h0, 4'h0});
      checkOutput("reset ready/busy", {cmdIf.CMD_READY, busy}, 2'b00);
      checkOutput("reset shadow", shadow, 4'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset RN", rn, 4'hF);
    checkOutput("post-reset ready", cmdIf.CMD_READY, 1'b1);
    checkOutput("post-reset err", {err, errMask}, 5'h00);
  endtask

  task automatic applyStimulus(input vec_t v);
    int waitCnt;
    cmdIf.CMD_VALID = 1'b1;
    cmdIf.CMD_OP    = v.op;
    cmdIf.CMD_MASK  = v.mask;
    cmdIf.CMD_REP   = v.rep;
    waitCnt = 0;
    while (cmdIf.CMD_READY !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (cmdIf.CMD_READY !== 1'b1) begin
      nChecks++;
      nMis++;
      $display("[TB] FAIL ready timeout: got %b, expected 1", cmdIf.CMD_READY);
      cmdIf.CMD_VALID = 1'b0;
      return;
    end
    @(negedge clk);
    cmdIf.CMD_VALID = 1'b0;
    for (int c = 0; c < v.cycles; c++) begin
      checkOutput($sformatf("drive op%0d cyc%0d", v.op, c),
                  {busy, cmdIf.CMD_READY, j, k, sn, rn},
                  {1'b1, 1'b0, v.expJ, v.expK, v.expSN, v.expRN});
      @(negedge clk);
    end
    checkOutput("check phase drive", {busy, cmdIf.CMD_READY, j, k, sn, rn},
                {1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF});
    checkOutput("check phase errmask", {err, errMask}, {|v.expErrMask, v.expErrMask});
    @(negedge clk);
    checkOutput("done ready/busy", {cmdIf.CMD_READY, busy}, 2'b10);
    checkOutput("done shadow", shadow, v.expShadow);
    checkOutput("done err", {err, errMask}, {|v.expErrMask, v.expErrMask});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t fv;
    vecs[0] = '{OP_SET,    4'b0101, 8'd0,   1,   4'h0, 4'h0, 4'hA, 4'hF, 4'h5, 4'h0};
    vecs[1] = '{OP_TOGGLE, 4'b0011, 8'd3,   3,   4'h3, 4'h3, 4'hF, 4'hF, 4'h6, 4'h0};
    vecs[2] = '{OP_CLEAR,  4'b0110, 8'd5,   1,   4'h0, 4'h0, 4'hF, 4'h9, 4'h0, 4'h0};
    vecs[3] = '{OP_TOGGLE, 4'b1111, 8'd0,   1,   4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    vecs[4] = '{OP_HOLD,   4'b1111, 8'd7,   1,   4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0};
    vecs[5] = '{OP_TOGGLE, 4'b0000, 8'd2,   2,   4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0};
    vecs[6] = '{OP_TOGGLE, 4'b1000, 8'd255, 255, 4'h8, 4'h8, 4'hF, 4'hF, 4'h7, 4'h0};
    vecs[7] = '{OP_CLEAR,  4'b0001, 8'd0,   1,   4'h0, 4'h0, 4'hF, 4'hE, 4'h6, 4'h0};
    vecs[8] = '{OP_TOGGLE, 4'b0100, 8'd4,   4,   4'h4, 4'h4, 4'hF, 4'hF, 4'h6, 4'h0};

    rst             = 1'b1;
    stuckMask       = 4'h0;
    cmdIf.CMD_VALID = 1'b0;
    cmdIf.CMD_OP    = OP_HOLD;
    cmdIf.CMD_MASK  = 4'h0;
    cmdIf.CMD_REP   = 8'd0;
    @(negedge clk);
    resetDut(2);

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    $display("[TB] stuck-at-0 on Q_FB bit 2");
    stuckMask = 4'b0100;
    fv = '{OP_SET, 4'b1111, 8'd0, 1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h4};
    applyStimulus(fv);
    fv = '{OP_HOLD, 4'b0000, 8'd0, 1, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h4};
    applyStimulus(fv);
    stuckMask = 4'h0;
    resetDut(1);

    $display("[TB] reset in the middle of a long toggle");
    cmdIf.CMD_VALID = 1'b1;
    cmdIf.CMD_OP    = OP_TOGGLE;
    cmdIf.CMD_MASK  = 4'hF;
    cmdIf.CMD_REP   = 8'd10;
    @(negedge clk);
    cmdIf.CMD_VALID = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid toggle drive", {busy, j, k}, {1'b1, 4'hF, 4'hF});
    resetDut(1);
    fv = '{OP_SET, 4'b0011, 8'd0, 1, 4'h0, 4'h0, 4'hC, 4'hF, 4'h3, 4'h0};
    applyStimulus(fv);

    $display("[TB] back-to-back commands with valid held high");
    for (int i = 0; i < 12; i++) begin
      cmdIf.CMD_VALID = 1'b1;
      cmdIf.CMD_OP    = (((i / 3) % 2) == 0) ? OP_CLEAR : OP_SET;
      cmdIf.CMD_MASK  = 4'hF;
      cmdIf.CMD_REP   = 8'd9;
      checkOutput($sformatf("b2b ready/busy %0d", i), {cmdIf.CMD_READY, busy},
                  ((i % 3) == 0) ? 2'b10 : 2'b01);
      checkOutput($sformatf("b2b SN|RN %0d", i), sn | rn, 4'hF);
      @(negedge clk);
    end
    cmdIf.CMD_VALID = 1'b0;
    checkOutput("b2b final ready", cmdIf.CMD_READY, 1'b1);
    checkOutput("b2b final shadow", shadow, 4'hF);
    checkOutput("b2b final err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMis);
    $finish;
  end

endmodule
